sobol_rng_gen: RTL and testbench

Sobol sequence generator that consumes least-significant-zero (LSZ) indices of an internal up-counter. Each cycle it selects a direction vector and XORs it into the running sequence value (Gray-code Sobol recurrence). It is the producer side of the stochastic-number-generator path: its `sobolSeq` output feeds the comparator stage of the SC unit. One instance provides one Sobol dimension, selected by its direction vectors, which can be loaded at run time.

---
 rtl/sobol_rng_gen.sv | 129 ++++++++++++
 tb/tb_sobol_rng_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sobol_rng_gen.sv
// Gray-code Sobol sequence generator: XORs the direction vector selected by the
// counter's least-significant zero into a running value. Optional: SOBOL_SCRAMBLE_EN.
module sobol_rng_gen #(
`ifdef INWD10
    localparam int INWD    = 10,
    localparam int LOGINWD = 4
`elsif INWD8
    localparam int INWD    = 8,
    localparam int LOGINWD = 3
`elsif INWD6
    localparam int INWD    = 6,
    localparam int LOGINWD = 3
`else
    localparam int INWD    = 4,
    localparam int LOGINWD = 2
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               dvWr,
    input  logic [LOGINWD:0]   dvIdx,
    input  logic [INWD-1:0]    dvData,
    output logic [INWD-1:0]    sobolSeq,
    output logic               valid,
    output logic               wrap
);

    logic [INWD-1:0]            cnt_reg;
    logic [INWD-1:0]            cnt_next;
    logic [INWD-1:0]            seq_reg;
    logic [INWD-1:0]            seq_next;
    logic [INWD-1:0]            out_next;
    logic                       wrap_next;
    logic                       cnt_full;
    logic [INWD-1:0]            lsz_onehot;
    logic [INWD-1:0][INWD-1:0]  dv_masked;
    logic [INWD-1:0]            dv_sel;

    assign cnt_full = &cnt_reg;

    // One direction-vector register per dimension bit; the LSZ one-hot gates
    // which vector reaches the XOR, so no binary index decode is needed.
    genvar gi;
    generate
        for (gi = 0; gi < INWD; gi++) begin : g_dv
            localparam logic [LOGINWD:0] DV_ADDR = (LOGINWD+1)'(gi);
            localparam logic [INWD-1:0]  DV_INIT = INWD'(1) << (INWD - 1 - gi);

            logic [INWD-1:0] dv_reg;

            if (gi == 0) begin : g_lsz_first
                assign lsz_onehot[gi] = ~cnt_reg[0];
            end else begin : g_lsz_rest
                assign lsz_onehot[gi] = ~cnt_reg[gi] & (&cnt_reg[gi-1:0]);
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dv_reg <= DV_INIT;
                end else if (dvWr && (dvIdx == DV_ADDR)) begin
                    dv_reg <= dvData;
                end
            end

            assign dv_masked[gi] = dv_reg & {INWD{lsz_onehot[gi]}};
        end
    endgenerate

    always_comb begin
        dv_sel = '0;
        for (int i = 0; i < INWD; i++) begin
            dv_sel = dv_sel | dv_masked[i];
        end
    end

    // At the last element of the period the counter has no zero bit, so the
    // sequence restarts from 0 instead of applying a vector.
    always_comb begin
        cnt_next  = cnt_reg;
        seq_next  = seq_reg;
        wrap_next = 1'b0;
        if (enable) begin
            if (cnt_full) begin
                cnt_next  = '0;
                seq_next  = '0;
                wrap_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + INWD'(1);
                seq_next = seq_reg ^ dv_sel;
            end
        end
    end

`ifdef SOBOL_SCRAMBLE_EN
    localparam logic [LOGINWD:0] SCR_ADDR = (LOGINWD+1)'(INWD);

    logic [INWD-1:0] scr_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scr_reg <= '0;
        end else if (dvWr && (dvIdx == SCR_ADDR)) begin
            scr_reg <= dvData;
        end
    end

    assign out_next = seq_next ^ scr_reg;
`else
    assign out_next = seq_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            seq_reg  <= '0;
            sobolSeq <= '0;
            valid    <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            seq_reg  <= seq_next;
            sobolSeq <= out_next;
            valid    <= enable;
            wrap     <= wrap_next;
        end
    end

endmodule

// File: tb/tb_sobol_rng_gen.sv
// Self-checking bench for sobol_rng_gen (INWD4): vector table plus directed
// sequences, expectations queued at drive time and popped after each edge.
module tb_sobol_rng_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       dvWr;
    logic [2:0] dvIdx;
    logic [3:0] dvData;
    logic [3:0] sobolSeq;
    logic       valid;
    logic       wrap;

    always #5 clk = ~clk;

    sobol_rng_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .dvWr     (dvWr),
        .dvIdx    (dvIdx),
        .dvData   (dvData),
        .sobolSeq (sobolSeq),
        .valid    (valid),
        .wrap     (wrap)
    );

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    typedef struct {
        string      name;
        logic [3:0] seq;
        logic       v;
        logic       w;
    } exp_t;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       wr;
        logic [2:0] idx;
        logic [3:0] data;
        logic [3:0] seq;
        logic       v;
        logic       w;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[17];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step(input string name, input logic r, input logic e, input logic w,
                        input logic [2:0] i, input logic [3:0] d,
                        input logic [3:0] es, input logic ev, input logic ew);
        exp_t x;
        rst_n  = r;
        enable = e;
        dvWr   = w;
        dvIdx  = i;
        dvData = d;
        x.name = name;
        x.seq  = es;
        x.v    = ev;
        x.w    = ew;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({x.name, ".seq"},   sobolSeq,        x.seq);
        check({x.name, ".valid"}, {3'b000, valid}, {3'b000, x.v});
        check({x.name, ".wrap"},  {3'b000, wrap},  {3'b000, x.w});
        $display("txn %0d %s seq=%0d valid=%0d wrap=%0d", txn, x.name, sobolSeq, valid, wrap);
        txn++;
    endtask

    task automatic rst_cyc(input string name);
        step(name, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic en_cyc(input string name, input logic [3:0] es);
        step(name, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, es, 1'b1, 1'b0);
    endtask

    task automatic wr_idle(input string name, input logic [2:0] i, input logic [3:0] d,
                           input logic [3:0] es);
        step(name, 1'b1, 1'b0, 1'b1, i, d, es, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int period_exp[17];
        period_exp = '{8, 12, 4, 6, 14, 10, 2, 3, 11, 15, 7, 5, 13, 9, 1, 0, 8};

        rst_n  = 1'b0;
        enable = 1'b0;
        dvWr   = 1'b0;
        dvIdx  = '0;
        dvData = '0;

        // Reset with a direction-vector write in flight: the write must be dropped.
        step("rst_wr", 1'b0, 1'b0, 1'b1, 3'd0, 4'hF, 4'd0, 1'b0, 1'b0);
        rst_cyc("rst");

        // Full period plus one element across the wrap.
        for (int i = 0; i < 17; i++) begin
            vecs[i].rst_n = 1'b1;
            vecs[i].en    = 1'b1;
            vecs[i].wr    = 1'b0;
            vecs[i].idx   = 3'd0;
            vecs[i].data  = 4'd0;
            vecs[i].seq   = 4'(period_exp[i]);
            vecs[i].v     = 1'b1;
            vecs[i].w     = (i == 15);
        end
        for (int i = 0; i < 17; i++) begin
            step($sformatf("period[%0d]", i), vecs[i].rst_n, vecs[i].en, vecs[i].wr,
                 vecs[i].idx, vecs[i].data, vecs[i].seq, vecs[i].v, vecs[i].w);
        end

        // Enable toggling: value holds, valid drops.
        rst_cyc("rst_toggle");
        step("tog0", 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 4'd8,  1'b1, 1'b0);
        step("tog1", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd8,  1'b0, 1'b0);
        step("tog2", 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 4'd12, 1'b1, 1'b0);
        step("tog3", 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd12, 1'b0, 1'b0);

        // Idle write of dv[0], then use it.
        rst_cyc("rst_dvload");
        wr_idle("dv0_wr", 3'd0, 4'hF, 4'd0);
        en_cyc("dv0_e0", 4'd15);
        en_cyc("dv0_e1", 4'd11);

        // Write colliding with an enable: old vector used this cycle.
        rst_cyc("rst_coll");
        step("coll_e0", 1'b1, 1'b1, 1'b1, 3'd0, 4'd1, 4'd8, 1'b1, 1'b0);
        en_cyc("coll_e1", 4'd12);
        en_cyc("coll_e2", 4'd13);

        // Reset mid-sequence restores the default vectors.
        rst_cyc("rst_mid");
        wr_idle("mid_wr", 3'd0, 4'hF, 4'd0);
        en_cyc("mid_e0", 4'd15);
        en_cyc("mid_e1", 4'd11);
        en_cyc("mid_e2", 4'd4);
        en_cyc("mid_e3", 4'd6);
        en_cyc("mid_e4", 4'd9);
        step("mid_rst", 1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        en_cyc("mid_e5", 4'd8);
        en_cyc("mid_e6", 4'd12);

        // Out-of-range addresses are ignored.
        rst_cyc("rst_oor");
        wr_idle("oor_wr5", 3'd5, 4'd0, 4'd0);
        wr_idle("oor_wr7", 3'd7, 4'd0, 4'd0);
        en_cyc("oor_e0", 4'd8);
        en_cyc("oor_e1", 4'd12);

        // Scramble address.
        rst_cyc("rst_scr");
        wr_idle("scr_wr", 3'd4, 4'h5, 4'd0);
`ifdef SOBOL_SCRAMBLE_EN
        en_cyc("scr_e0", 4'd13);
        en_cyc("scr_e1", 4'd9);
        en_cyc("scr_e2", 4'd1);
`else
        en_cyc("scr_e0", 4'd8);
        en_cyc("scr_e1", 4'd12);
        en_cyc("scr_e2", 4'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
